// File: rtl/nrs_seq_ctrl.sv
// nrs_seq_ctrl: frame/slot/symbol sequencer for the NRS Gold-sequence
// generator. For every NRS symbol it computes c_init, seeds the LFSRs,
// fast-forwards them and then writes four c(n) bits into the pilot memory.
// A subframe's worth of bits (2 slots x 2 symbols x 4 bits) is handed to the
// mapper through a subframe_ready/new_subframe handshake.
module nrs_seq_ctrl #(
  parameter int WIDTH_B    = 9,
  parameter int NUM_SHIFTS = 1570,
  parameter int ADDR_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_frame,
  input  logic               new_subframe,
  input  logic [WIDTH_B-1:0] N_cell_ID,
  output logic               seed_ld,
  output logic [27:0]        cinit,
  output logic               shift_en,
  output logic               cn_wr_en,
  output logic [ADDR_W-1:0]  cn_wr_addr,
  output logic               subframe_ready,
  output logic [4:0]         ns,
  output logic               busy
);

  localparam int CNT_W = (NUM_SHIFTS > 1) ? $clog2(NUM_SHIFTS) : 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(NUM_SHIFTS - 1);
  localparam int PW = WIDTH_B + 9;

  typedef enum logic [2:0] {
    IDLE, CALC, SEED, SHIFT, CAPT, NEXT, WAIT_SF
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         ns_q;
  logic               l6_q;       // symbol index: 0 -> l=5, 1 -> l=6
  logic [WIDTH_B-1:0] cell_q;
  logic [27:0]        cinit_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         idx_q;
  logic               sf_rdy_q;

  // c_init = (7*(ns+1)+l+1)*(2N+1)*2^10 + (2N+1). The low 10 bits of the
  // shifted product are zero, so the add is a plain concatenation.
  logic [7:0]     sym_mult;
  logic [WIDTH_B:0] cell_odd;
  logic [PW-1:0]  prod;
  logic [27:0]    cinit_d;

  assign sym_mult = ({3'b0, ns_q} + 8'd1) * 8'd7 + (l6_q ? 8'd7 : 8'd6);
  assign cell_odd = {cell_q, 1'b1};
  assign prod     = PW'(sym_mult) * PW'(cell_odd);
  assign cinit_d  = 28'({prod, cell_odd});

  // State register; async reset drops every Moore output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; new_frame overrides everything and
  // suppresses a write that would otherwise land in the abort cycle.
  always_comb begin
    state_d  = state_q;
    seed_ld  = 1'b0;
    shift_en = 1'b0;
    cn_wr_en = 1'b0;
    case (state_q)
      IDLE:    state_d = IDLE;
      CALC:    state_d = SEED;
      SEED: begin
        seed_ld = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == SHIFT_LAST) state_d = CAPT;
      end
      CAPT: begin
        shift_en = 1'b1;
        cn_wr_en = 1'b1;
        if (idx_q == 2'd3) state_d = NEXT;
      end
      NEXT:    state_d = (l6_q && ns_q[0]) ? WAIT_SF : CALC;
      WAIT_SF: if (new_subframe) state_d = (ns_q == 5'd19) ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
    if (new_frame) begin
      state_d  = CALC;
      cn_wr_en = 1'b0;
    end
  end

  // Slot/symbol position, cell ID, c_init and the per-symbol counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_q     <= 5'd0;
      l6_q     <= 1'b0;
      cell_q   <= '0;
      cinit_q  <= 28'd0;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      sf_rdy_q <= 1'b0;
    end else if (new_frame) begin
      cell_q   <= N_cell_ID;
      ns_q     <= 5'd0;
      l6_q     <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      sf_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        CALC: cinit_q <= cinit_d;
        SEED: cnt_q <= '0;
        SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          idx_q <= 2'd0;
        end
        CAPT: idx_q <= idx_q + 2'd1;
        NEXT: begin
          if (!l6_q) begin
            l6_q <= 1'b1;
          end else if (!ns_q[0]) begin
            ns_q <= ns_q + 5'd1;
            l6_q <= 1'b0;
          end else begin
            sf_rdy_q <= 1'b1;
          end
        end
        WAIT_SF: begin
          if (new_subframe) begin
            sf_rdy_q <= 1'b0;
            l6_q     <= 1'b0;
            // subframe 5 (slots 10/11) carries no NRS
            if (ns_q == 5'd19)     ns_q <= 5'd0;
            else if (ns_q == 5'd9) ns_q <= 5'd12;
            else                   ns_q <= ns_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cinit          = cinit_q;
  assign cn_wr_addr     = ADDR_W'({ns_q[0], l6_q, idx_q});
  assign subframe_ready = sf_rdy_q;
  assign ns             = ns_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_nrs_seq_ctrl.sv
// Bench for nrs_seq_ctrl: table of c_init/latency vectors, hand sequences for
// abort/reset corners, and whole frames with random handshake timing checked
// against an event-level model of the symbol schedule.
module tb_nrs_seq_ctrl;
  localparam int NSH = 25;

  logic        clk = 1'b0;
  logic        rst, new_frame, new_subframe;
  logic [8:0]  N_cell_ID;
  logic        seed_ld, shift_en, cn_wr_en, subframe_ready, busy;
  logic [27:0] cinit;
  logic [3:0]  cn_wr_addr;
  logic [4:0]  ns;

  nrs_seq_ctrl #(.WIDTH_B(9), .NUM_SHIFTS(NSH), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .new_subframe(new_subframe),
    .N_cell_ID(N_cell_ID), .seed_ld(seed_ld), .cinit(cinit),
    .shift_en(shift_en), .cn_wr_en(cn_wr_en), .cn_wr_addr(cn_wr_addr),
    .subframe_ready(subframe_ready), .ns(ns), .busy(busy)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // c_init straight from its defining formula
  function automatic logic [31:0] ref_cinit(input int n, input int s, input int l);
    int c;
    c = 2 * n + 1;
    return ((7 * (s + 1) + l + 1) * c) * 1024 + c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // edges from the new_frame edge to the edge that samples seed_ld
  task automatic seed_latency(output int lat);
    int c;
    c = 0;
    while (!seed_ld && c < 20) begin
      step();
      c++;
    end
    lat = c + 1;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (!subframe_ready && t < 5000) begin
      step();
      t++;
    end
    ok = subframe_ready;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  // ---------------- event-level schedule monitor ----------------
  typedef struct { int s; int l; } sym_t;
  sym_t exp_q[$];
  sym_t cur;
  bit   mon_on = 0;
  int   mon_n, phase, shifts, widx, sf_cnt;
  int   used[16];
  bit   saw_skip, rdy_prev;

  initial begin
    cur = '{0, 5};
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ns == 5'd10 || ns == 5'd11) saw_skip = 1;
        if (seed_ld) begin
          chk("seed_shift_excl", shift_en, 0);
          if (exp_q.size() == 0) chk("seed_unexpected", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("cinit", cinit, ref_cinit(mon_n, cur.s, cur.l));
            chk("ns_at_seed", ns, cur.s);
          end
          phase = 1;
          shifts = 0;
        end else if (cn_wr_en) begin
          if (phase == 1) begin
            chk("shift_count", shifts, NSH);
            phase = 2;
            widx = 0;
          end
          chk("wr_addr", cn_wr_addr, (cur.s % 2) * 8 + (cur.l == 6 ? 4 : 0) + widx);
          used[cn_wr_addr]++;
          widx++;
        end else if (shift_en) begin
          if (phase != 1) chk("shift_phase", phase, 1);
          else shifts++;
        end
        if (subframe_ready && !rdy_prev) begin
          int bad;
          sf_cnt++;
          chk("ready_ns", ns, cur.s);
          chk("ready_sym_done", (cur.s % 2 == 1 && cur.l == 6 && widx == 4), 1);
          bad = 0;
          for (int a = 0; a < 16; a++) begin
            if (used[a] != 1) bad++;
            used[a] = 0;
          end
          chk("addr_cover", bad, 0);
        end
        rdy_prev = subframe_ready;
      end
    end
  end

  // whole frame with random handshake delays and stray new_subframe pulses
  task automatic run_frame(input int n);
    bit ok;
    int d, exp_odd, exp_next;
    exp_q.delete();
    for (int s = 0; s < 20; s++)
      if (s != 10 && s != 11) begin
        exp_q.push_back('{s, 5});
        exp_q.push_back('{s, 6});
      end
    for (int a = 0; a < 16; a++) used[a] = 0;
    mon_n = n; phase = 0; sf_cnt = 0; saw_skip = 0; rdy_prev = 0;
    N_cell_ID = 9'(n);
    new_frame = 1; step(); new_frame = 0;
    mon_on = 1;
    for (int sf = 0; sf < 9; sf++) begin
      int t;
      t = 0;
      while (!subframe_ready && t < 5000) begin
        new_subframe = ($urandom_range(0, 30) == 0);
        step();
        t++;
      end
      new_subframe = 0;
      if (!subframe_ready) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      exp_odd = (sf < 5) ? 2 * sf + 1 : 2 * sf + 3;
      d = $urandom_range(0, 4);
      for (int k = 0; k < d; k++) step();
      chk("stall_ready", subframe_ready, 1);
      chk("stall_ns", ns, exp_odd);
      new_subframe = 1; step(); new_subframe = 0;
      exp_next = (sf == 8) ? 0 : (exp_odd == 9 ? 12 : exp_odd + 1);
      chk("ready_drop", subframe_ready, 0);
      chk("ns_next", ns, exp_next);
      if (sf == 8) chk("busy_end", busy, 0);
    end
    step(); step();
    mon_on = 0;
    chk("sf_count", sf_cnt, 9);
    chk("skip_hidden", saw_skip, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  typedef struct { logic [8:0] n; logic [31:0] exp_cinit; } vec_t;
  vec_t tbl[5];

  initial begin
    int lat;
    bit ok;
    int rn;
    tbl[0] = '{9'd0,   32'd13313};
    tbl[1] = '{9'd1,   32'd39939};
    tbl[2] = '{9'd503, 32'd13406191};
    tbl[3] = '{9'd504, 32'd13432817};
    tbl[4] = '{9'd511, 32'd13619199};

    rst = 1; new_frame = 0; new_subframe = 0; N_cell_ID = 9'd0;
    step(); step();
    rst = 0;
    step();
    chk("reset_strobes", {seed_ld, shift_en, cn_wr_en, subframe_ready, busy}, 0);
    chk("reset_ns", ns, 0);
    chk("reset_cinit", cinit, 0);
    chk("reset_addr", cn_wr_addr, 0);

    // first-symbol c_init and latency; each new_frame also aborts the last run
    for (int i = 0; i < 5; i++) begin
      N_cell_ID = tbl[i].n;
      new_frame = 1; step(); new_frame = 0;
      seed_latency(lat);
      chk("seed_latency", lat, 2);
      chk("tbl_cinit", cinit, tbl[i].exp_cinit);
      for (int k = 0; k < int'($urandom_range(0, 40)); k++) step();
    end

    // new_frame landing in a write cycle suppresses that write
    N_cell_ID = 9'd5;
    new_frame = 1; step(); new_frame = 0;
    begin
      int t;
      t = 0;
      while (!cn_wr_en && t < 200) begin step(); t++; end
    end
    chk("capt_reached", cn_wr_en, 1);
    step();
    N_cell_ID = 9'd7;
    new_frame = 1; #1;
    chk("no_wr_on_abort", cn_wr_en, 0);
    step(); new_frame = 0;
    chk("abort_ns", ns, 0);
    seed_latency(lat);
    chk("abort_latency", lat, 2);
    chk("abort_cinit", cinit, ref_cinit(7, 0, 5));

    // asynchronous reset in the middle of a fast-forward
    N_cell_ID = 9'd2;
    new_frame = 1; step(); new_frame = 0;
    for (int k = 0; k < 10; k++) step();
    chk("midshift_shift_en", shift_en, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_strobes", {seed_ld, shift_en, cn_wr_en, subframe_ready, busy}, 0);
    chk("async_rst_ns", ns, 0);
    chk("async_rst_cinit", cinit, 0);
    step();
    rst = 0;
    step();
    N_cell_ID = 9'd2;
    new_frame = 1; step(); new_frame = 0;
    seed_latency(lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_cinit", cinit, ref_cinit(2, 0, 5));

    // full frames against the schedule model (N=503 covers slot 19, l=6)
    run_frame(503);
    run_frame(1);
    rn = $urandom_range(0, 511);
    run_frame(rn);

    // new_frame (together with new_subframe) while subframe 3 waits
    N_cell_ID = 9'd9;
    new_frame = 1; step(); new_frame = 0;
    for (int sf = 0; sf < 4; sf++) begin
      wait_ready(ok);
      if (sf < 3) begin
        new_subframe = 1; step(); new_subframe = 0;
      end
    end
    chk("sf3_ns", ns, 7);
    N_cell_ID = 9'd300;
    new_frame = 1; new_subframe = 1; step();
    new_frame = 0; new_subframe = 0;
    chk("sf3_abort_ready", subframe_ready, 0);
    chk("sf3_abort_ns", ns, 0);
    chk("sf3_abort_busy", busy, 1);
    seed_latency(lat);
    chk("sf3_abort_latency", lat, 2);
    chk("sf3_abort_cinit", cinit, ref_cinit(300, 0, 5));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
